// File: rtl/interrupt_cont_gen.sv
// interrupt_cont_gen: parametrised multi-source interrupt controller.
// Each source has mask, edge/level mode and polarity; edge events latch into
// PEND (write-1-to-clear via STATUS, test injection via SET). Bus strobes are
// registered once and a write fires on the rising edge of the synced Wr.
// Optional feature macro: INTCONT_VECTOR_EN enables the VECTOR register
// (lowest pending+unmasked source index); when undefined VECTOR reads 0.
module interrupt_cont_gen #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         Addr,
    output logic [15:0]        DataRd,
    input  logic [15:0]        DataWr,
    input  logic               En,
    input  logic               Rd,
    input  logic               Wr,
    input  logic [NUM_SRC-1:0] IntSrc,
    output logic               IntReq
);

    localparam logic [3:0] ADDR_MASK   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_RAW    = 4'd2;
    localparam logic [3:0] ADDR_MODE   = 4'd3;
    localparam logic [3:0] ADDR_POL    = 4'd4;
    localparam logic [3:0] ADDR_SET    = 4'd5;
    localparam logic [3:0] ADDR_VECTOR = 4'd6;

    // Bus strobe synchronisation
    logic [3:0] addr_sync;
    logic       en_sync;
    logic       wr_sync;
    logic       wr_sync_prev;
    logic       wr_pos;

    // Source path state
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] src_sync;
    logic [NUM_SRC-1:0] a_prev;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pol;
    logic [NUM_SRC-1:0] pend;

    // Next-state and decode signals
    logic [NUM_SRC-1:0] wr_data;
    logic [NUM_SRC-1:0] mask_n;
    logic [NUM_SRC-1:0] mode_n;
    logic [NUM_SRC-1:0] pol_n;
    logic [NUM_SRC-1:0] pend_n;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] edge_hit;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] cfg_chg;
    logic [NUM_SRC-1:0] pend_act;
    logic [15:0]        vector_word;

    // Rd is part of the bus bundle but carries no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{Rd, DataWr};

    // Zero-extend a per-source vector into a 16-bit register read word.
    function automatic logic [15:0] widen(input logic [NUM_SRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign wr_pos   = wr_sync & ~wr_sync_prev & en_sync;
    assign wr_data  = DataWr[NUM_SRC-1:0];
    assign active   = src_sync[SYNC_STAGES-1] ^ pol;
    assign edge_hit = active & ~a_prev;
    assign pend_act = pend & mask;

    // Decode the single-cycle write pulse into register updates and PEND next state.
    always_comb begin
        mask_n   = mask;
        mode_n   = mode;
        pol_n    = pol;
        w1c      = '0;
        set_bits = '0;
        if (wr_pos) begin
            case (addr_sync)
                ADDR_MASK:   mask_n   = wr_data;
                ADDR_STATUS: w1c      = wr_data;
                ADDR_MODE:   mode_n   = wr_data;
                ADDR_POL:    pol_n    = wr_data;
                ADDR_SET:    set_bits = wr_data;
                default:     ;
            endcase
        end
        // Reconfigured bits restart from a clean pending state; set beats clear.
        cfg_chg = (mode ^ mode_n) | (pol ^ pol_n);
        pend_n  = ~cfg_chg & ((mode & ((pend & ~w1c) | edge_hit | set_bits)) |
                              (~mode & active));
    end

    // Register bus strobes once; a held Wr gives one rising edge only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_sync    <= '0;
            en_sync      <= 1'b0;
            wr_sync      <= 1'b0;
            wr_sync_prev <= 1'b0;
        end else begin
            addr_sync    <= Addr;
            en_sync      <= En;
            wr_sync      <= Wr;
            wr_sync_prev <= wr_sync;
        end
    end

    // Synchronise sources, update config/pending registers and the request flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            src_sync <= '0;
            a_prev   <= '0;
            mask     <= '0;
            mode     <= '0;
            pol      <= '0;
            pend     <= '0;
            IntReq   <= 1'b0;
        end else begin
            src_sync <= {src_sync[SYNC_STAGES-2:0], IntSrc};
            // Reload history with the post-write polarity so a POL change
            // cannot look like an edge on the following cycle.
            a_prev   <= src_sync[SYNC_STAGES-1] ^ pol_n;
            mask     <= mask_n;
            mode     <= mode_n;
            pol      <= pol_n;
            pend     <= pend_n;
            IntReq   <= |pend_act;
        end
    end

`ifdef INTCONT_VECTOR_EN
    logic [3:0] vec_idx;

    // Priority encoder: scanning downward leaves the lowest active index.
    always_comb begin
        vec_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_act[i]) vec_idx = 4'(i);
        end
    end

    assign vector_word = (|pend_act) ? {1'b1, 11'b0, vec_idx} : 16'h0000;
`else
    assign vector_word = 16'h0000;
`endif

    // Read mux is combinational on the raw bus address.
    always_comb begin
        DataRd = 16'h0000;
        case (Addr)
            ADDR_MASK:   DataRd = widen(mask);
            ADDR_STATUS: DataRd = widen(pend_act);
            ADDR_RAW:    DataRd = widen(pend);
            ADDR_MODE:   DataRd = widen(mode);
            ADDR_POL:    DataRd = widen(pol);
            ADDR_VECTOR: DataRd = vector_word;
            default:     DataRd = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_interrupt_cont_gen.sv
// Directed testbench for interrupt_cont_gen (NUM_SRC=16, SYNC_STAGES=2).
// Timing reference: inputs change 1 ns after a rising edge; a change made
// there reaches PEND on the third following edge and IntReq on the fourth.
module tb_interrupt_cont_gen;

    localparam logic [3:0] A_MASK   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_RAW    = 4'd2;
    localparam logic [3:0] A_MODE   = 4'd3;
    localparam logic [3:0] A_POL    = 4'd4;
    localparam logic [3:0] A_SET    = 4'd5;
    localparam logic [3:0] A_VECTOR = 4'd6;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  Addr;
    logic [15:0] DataRd;
    logic [15:0] DataWr;
    logic        En;
    logic        Rd;
    logic        Wr;
    logic [15:0] IntSrc;
    logic        IntReq;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_vec;

    always #50 Clk = ~Clk;

    interrupt_cont_gen #(
        .NUM_SRC    (16),
        .SYNC_STAGES(2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .DataRd(DataRd),
        .DataWr(DataWr),
        .En    (En),
        .Rd    (Rd),
        .Wr    (Wr),
        .IntSrc(IntSrc),
        .IntReq(IntReq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        Addr = a;
        #1;
        check(tag, DataRd, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {15'b0, IntReq}, {15'b0, exp});
    endtask

    // Wr rises before edge k, register updates at k+1, Wr falls, then one idle edge.
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
        tick();
        tick();
        Wr = 1'b0; En = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; Addr = '0; DataWr = '0; En = 1'b0; Rd = 1'b0; Wr = 1'b0; IntSrc = '0;
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Reset state
        check_reg("rst_mask",   A_MASK,   16'h0000);
        check_reg("rst_status", A_STATUS, 16'h0000);
        check_reg("rst_raw",    A_RAW,    16'h0000);
        check_reg("rst_mode",   A_MODE,   16'h0000);
        check_reg("rst_pol",    A_POL,    16'h0000);
        check_reg("rst_vector", A_VECTOR, 16'h0000);
        check_reg("rst_addr15", 4'd15,    16'h0000);
        check_irq("rst_irq", 1'b0);

        // Level activity visible on RAW with MASK = 0, exact sync latency
        IntSrc = 16'h0008;
        tick(); tick();
        check_reg("lvl_raw_early", A_RAW, 16'h0000);
        tick();
        check_reg("lvl_raw",    A_RAW,    16'h0008);
        check_reg("lvl_status", A_STATUS, 16'h0000);
        tick();
        check_irq("lvl_masked_irq", 1'b0);
        IntSrc = 16'h0000;
        tick(); tick(); tick();
        check_reg("lvl_raw_fall", A_RAW, 16'h0000);

        // Edge latch on source 0
        bus_write(A_MODE, 16'h0001);
        bus_write(A_MASK, 16'h0001);
        check_reg("edge_mode_rb", A_MODE, 16'h0001);
        IntSrc = 16'h0001;
        tick();
        IntSrc = 16'h0000;
        tick(); tick();
        check_reg("edge_status", A_STATUS, 16'h0001);
        check_irq("edge_irq_early", 1'b0);
        tick();
        check_irq("edge_irq", 1'b1);
        tick(); tick();
        check_reg("edge_persist", A_STATUS, 16'h0001);

        // W1C with exact timing: PEND at k+1, IntReq low at k+2
        Addr = A_STATUS; DataWr = 16'h0001; En = 1'b1; Wr = 1'b1;
        tick();
        check_reg("w1c_k_status", A_STATUS, 16'h0001);
        check_irq("w1c_k_irq", 1'b1);
        tick();
        check_reg("w1c_k1_status", A_STATUS, 16'h0000);
        check_irq("w1c_k1_irq", 1'b1);
        tick();
        check_irq("w1c_k2_irq", 1'b0);
        Wr = 1'b0; En = 1'b0;
        tick();

        // Held Wr performs one clear only; a later edge must stay latched
        Addr = A_STATUS; DataWr = 16'h0001; En = 1'b1; Wr = 1'b1;
        tick(); tick(); tick();
        IntSrc = 16'h0001;
        tick();
        IntSrc = 16'h0000;
        tick(); tick(); tick(); tick();
        check_reg("held_wr_single", A_STATUS, 16'h0001);
        Wr = 1'b0; En = 1'b0;
        tick();
        bus_write(A_STATUS, 16'h0001);
        check_reg("w1c_again", A_STATUS, 16'h0000);

        // Level + active-low polarity on source 2
        bus_write(A_MODE, 16'h0000);
        bus_write(A_POL,  16'h0004);
        bus_write(A_MASK, 16'h0004);
        check_reg("pol_status", A_STATUS, 16'h0004);
        check_reg("pol_raw",    A_RAW,    16'h0004);
        check_irq("pol_irq", 1'b1);
        IntSrc = 16'h0004;
        tick(); tick();
        check_reg("pol_status_hold", A_STATUS, 16'h0004);
        tick();
        check_reg("pol_status_drop", A_STATUS, 16'h0000);
        tick();
        check_irq("pol_irq_drop", 1'b0);
        IntSrc = 16'h0000;
        bus_write(A_POL, 16'h0000);
        tick();
        check_reg("pol_restore_raw", A_RAW, 16'h0000);

        // Hardware edge and W1C on bit 5 land on the same edge: set wins
        bus_write(A_MODE, 16'hFFFF);
        IntSrc = 16'h0020;
        tick();
        Addr = A_STATUS; DataWr = 16'h0020; En = 1'b1; Wr = 1'b1;
        tick(); tick();
        Wr = 1'b0; En = 1'b0;
        tick();
        check_reg("race_set_wins", A_RAW, 16'h0020);
        bus_write(A_STATUS, 16'h0020);
        check_reg("race_then_clear", A_RAW, 16'h0000);
        IntSrc = 16'h0000;
        tick(); tick(); tick();

        // SET affects edge sources only; MODE change clears and follows level
        bus_write(A_MODE, 16'h8000);
        bus_write(A_SET,  16'h8001);
        check_reg("set_raw", A_RAW, 16'h8000);
        check_reg("set_reads_zero", A_SET, 16'h0000);
        bus_write(A_MODE, 16'h0000);
        check_reg("mode_chg_clear", A_RAW, 16'h0000);
        IntSrc = 16'h8000;
        tick(); tick(); tick();
        check_reg("mode_chg_level_hi", A_RAW, 16'h8000);
        IntSrc = 16'h0000;
        tick(); tick(); tick();
        check_reg("mode_chg_level_lo", A_RAW, 16'h0000);

        // POL change on an edge source must not create an edge; falling edge latches
        bus_write(A_MODE, 16'h0002);
        bus_write(A_POL,  16'h0002);
        tick(); tick(); tick();
        check_reg("pol_chg_no_edge", A_RAW, 16'h0000);
        IntSrc = 16'h0002;
        tick(); tick(); tick();
        check_reg("fall_src_high", A_RAW, 16'h0000);
        IntSrc = 16'h0000;
        tick(); tick(); tick();
        check_reg("fall_edge_latch", A_RAW, 16'h0002);

        // Unmasking an already pending source raises IntReq
        bus_write(A_MASK, 16'h0000);
        check_reg("unmask_pre_status", A_STATUS, 16'h0000);
        check_irq("unmask_pre_irq", 1'b0);
        bus_write(A_MASK, 16'h0002);
        check_reg("unmask_status", A_STATUS, 16'h0002);
        check_reg("unmask_raw",    A_RAW,    16'h0002);
        check_irq("unmask_irq", 1'b1);

        // Reset in the middle of a write: the write is lost
        Addr = A_MASK; DataWr = 16'hFFFF; En = 1'b1; Wr = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; Wr = 1'b0; En = 1'b0;
        tick(); tick();
        check_reg("rstw_mask", A_MASK, 16'h0000);
        check_reg("rstw_mode", A_MODE, 16'h0000);
        check_reg("rstw_pol",  A_POL,  16'h0000);
        check_reg("rstw_raw",  A_RAW,  16'h0000);
        check_irq("rstw_irq", 1'b0);

        // VECTOR register
        bus_write(A_MODE, 16'hFFFF);
        bus_write(A_MASK, 16'h00F0);
        bus_write(A_SET,  16'h00A0);
        check_reg("vec_raw", A_RAW, 16'h00A0);
`ifdef INTCONT_VECTOR_EN
        exp_vec = 16'h8005;
`else
        exp_vec = 16'h0000;
`endif
        check_reg("vec_first", A_VECTOR, exp_vec);
        bus_write(A_STATUS, 16'h0020);
`ifdef INTCONT_VECTOR_EN
        exp_vec = 16'h8007;
`else
        exp_vec = 16'h0000;
`endif
        check_reg("vec_second", A_VECTOR, exp_vec);
        bus_write(A_STATUS, 16'h0080);
        check_reg("vec_none", A_VECTOR, 16'h0000);
        check_reg("unmapped_7", 4'd7, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
